// File: rtl/coffee_brew_timer.sv
// Pump/drip sequencer downstream of the coffee controller FSM; drives its S (stop) and P (fault) inputs.
// Optional pre-infusion phase is compiled in with `define BREW_TIMER_PREINFUSE_EN.
//   state    | meaning
//   IDLE     | waiting for a fresh brew rising edge
//   PRE_ON   | short pump burst to wet the grounds (pre-infusion build only)
//   PRE_SOAK | pump off while the grounds soak (pre-infusion build only)
//   POUR     | pump on for the latched cup length
//   DRIP     | pump off, letting the basket drain
//   DONE     | stop asserted until the controller drops brew
//   FAULT    | water lost; sticky until reset
module coffee_brew_timer #(
   parameter int CLK_DIV        = 50000,
   parameter int SMALL_TICKS    = 8000,
   parameter int MEDIUM_TICKS   = 12000,
   parameter int LARGE_TICKS    = 16000,
   parameter int DRIP_TICKS     = 2000,
`ifdef BREW_TIMER_PREINFUSE_EN
   parameter int PRE_ON_TICKS   = 500,
   parameter int PRE_SOAK_TICKS = 1500,
`endif
   parameter int CNT_WIDTH      = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 brew,
   input  logic [1:0]           cup_size,
   input  logic                 water_ok,
   input  logic                 abort,
   output logic                 pump,
   output logic                 stop,
   output logic                 fault,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] pour_count
);

   localparam int PW = $clog2(CLK_DIV);

   typedef enum logic [2:0] {
      IDLE, POUR, DRIP, DONE, FAULT
`ifdef BREW_TIMER_PREINFUSE_EN
      , PRE_ON, PRE_SOAK
`endif
   } state_t;

`ifdef BREW_TIMER_PREINFUSE_EN
   localparam state_t START = PRE_ON;
`else
   localparam state_t START = POUR;
`endif

   state_t               state, nxt;
   logic                 brew_q, primed;
   logic [PW-1:0]        presc;
   logic [CNT_WIDTH-1:0] tick_cnt, target, cur_len, cup_ticks;
   logic                 tick, expire, rise;

   // primed masks the first cycle after reset so a brew held high across reset is not seen as an edge
   assign rise   = brew & ~brew_q & primed;
   assign tick   = (presc == PW'(CLK_DIV - 1));
   assign expire = tick && (tick_cnt == cur_len - CNT_WIDTH'(1));

   always_comb begin
      case (cup_size)
         2'b00:   cup_ticks = CNT_WIDTH'(SMALL_TICKS);
         2'b01:   cup_ticks = CNT_WIDTH'(MEDIUM_TICKS);
         default: cup_ticks = CNT_WIDTH'(LARGE_TICKS);
      endcase
   end

   always_comb begin
      cur_len = '0;
      case (state)
         POUR:     cur_len = target;
         DRIP:     cur_len = CNT_WIDTH'(DRIP_TICKS);
`ifdef BREW_TIMER_PREINFUSE_EN
         PRE_ON:   cur_len = CNT_WIDTH'(PRE_ON_TICKS);
         PRE_SOAK: cur_len = CNT_WIDTH'(PRE_SOAK_TICKS);
`endif
         default:  cur_len = '0;
      endcase
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE: if (rise) nxt = water_ok ? START : FAULT;
`ifdef BREW_TIMER_PREINFUSE_EN
         PRE_ON, PRE_SOAK,
`endif
         POUR: begin
            if (!brew)          nxt = IDLE;
            else if (!water_ok) nxt = FAULT;
            else if (abort)     nxt = DONE;
            else if (expire) begin
`ifdef BREW_TIMER_PREINFUSE_EN
               nxt = (state == PRE_ON) ? PRE_SOAK : (state == PRE_SOAK) ? POUR : DRIP;
`else
               nxt = DRIP;
`endif
            end
         end
         DRIP: begin
            if (!brew)                nxt = IDLE;
            else if (abort || expire) nxt = DONE;
         end
         DONE:    if (!brew) nxt = IDLE;
         default: nxt = state;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         pump       <= 1'b0;
         stop       <= 1'b0;
         fault      <= 1'b0;
         busy       <= 1'b0;
         pour_count <= '0;
         brew_q     <= 1'b0;
         primed     <= 1'b0;
         presc      <= '0;
         tick_cnt   <= '0;
         target     <= '0;
      end else begin
         brew_q <= brew;
         primed <= 1'b1;
         state  <= nxt;

         if (nxt != state) begin
            presc    <= '0;
            tick_cnt <= '0;
         end else if (tick) begin
            presc    <= '0;
            tick_cnt <= tick_cnt + CNT_WIDTH'(1);
         end else begin
            presc    <= presc + PW'(1);
         end

         if (state == IDLE && rise) target <= cup_ticks;

         // a tick on the same edge as an early exit is not counted as poured
         if (nxt == POUR && state != POUR)
            pour_count <= '0;
         else if (state == POUR && tick && (nxt == POUR || nxt == DRIP))
            pour_count <= pour_count + CNT_WIDTH'(1);

`ifdef BREW_TIMER_PREINFUSE_EN
         pump  <= (nxt == POUR) || (nxt == PRE_ON);
`else
         pump  <= (nxt == POUR);
`endif
         stop  <= (nxt == DONE);
         fault <= (nxt == FAULT);
         busy  <= (nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_coffee_brew_timer.sv
// Bench for coffee_brew_timer: directed scenarios with literal run lengths, then random stimulus
// compared every cycle against a cycle-timeline model of the brew sequence.
module tb_coffee_brew_timer;

   localparam int D = 4, SM = 3, MD = 5, LG = 7, DR = 2, PON = 1, PSK = 2, W = 16;
`ifdef BREW_TIMER_PREINFUSE_EN
   localparam int PRE_CYC = PON * D, SOAK_CYC = PSK * D;
`else
   localparam int PRE_CYC = 0, SOAK_CYC = 0;
`endif
   localparam int S_PUMP = 0, S_STOP = 1, S_BUSY = 2, S_FAULT = 3;

   logic clock = 1'b0, reset = 1'b1, brew = 1'b0, water_ok = 1'b1, abort = 1'b0;
   logic [1:0] cup_size = 2'b00;
   logic pump, stop, fault, busy;
   logic [W-1:0] pour_count;
   int n_checks = 0, n_pass = 0;

   always #5 clock = ~clock;

   coffee_brew_timer #(
      .CLK_DIV(D), .SMALL_TICKS(SM), .MEDIUM_TICKS(MD), .LARGE_TICKS(LG), .DRIP_TICKS(DR),
`ifdef BREW_TIMER_PREINFUSE_EN
      .PRE_ON_TICKS(PON), .PRE_SOAK_TICKS(PSK),
`endif
      .CNT_WIDTH(W)
   ) dut (
      .clock(clock), .reset(reset), .brew(brew), .cup_size(cup_size), .water_ok(water_ok),
      .abort(abort), .pump(pump), .stop(stop), .fault(fault), .busy(busy), .pour_count(pour_count)
   );

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
   endtask

   // Model: phase 0 idle, 1 brewing (m_t = cycles since start), 2 done, 3 fault.
   int m_phase, m_t, m_tgt, m_pc, m_ps, m_pe, m_tot;
   bit m_bq, m_primed, m_rise;

   function automatic int tgt_of(input logic [1:0] c);
      return (c == 2'b00) ? SM : (c == 2'b01) ? MD : LG;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_phase = 0; m_t = 0; m_tgt = 0; m_pc = 0; m_bq = 0; m_primed = 0;
      end else begin
         m_ps   = PRE_CYC + SOAK_CYC;
         m_pe   = m_ps + m_tgt * D;
         m_tot  = m_pe + DR * D;
         m_rise = brew && !m_bq && m_primed;
         case (m_phase)
            0: if (m_rise) begin
                  if (!water_ok) m_phase = 3;
                  else begin m_phase = 1; m_t = 0; m_tgt = tgt_of(cup_size); end
               end
            1: if (!brew) m_phase = 0;
               else if (m_t < m_pe) begin
                  if (!water_ok)  m_phase = 3;
                  else if (abort) m_phase = 2;
                  else            m_t++;
               end else begin
                  if (abort) m_phase = 2;
                  else begin m_t++; if (m_t == m_tot) m_phase = 2; end
               end
            2: if (!brew) m_phase = 0;
            default: ;
         endcase
         if (m_phase == 1) begin
            m_pe = m_ps + m_tgt * D;
            if (m_t >= m_ps && m_t <= m_pe) m_pc = (m_t - m_ps) / D;
         end
         m_bq = brew; m_primed = 1;
      end
   end

   function automatic int exp_pump();
      return (m_phase == 1 && (m_t < PRE_CYC ||
              (m_t >= PRE_CYC + SOAK_CYC && m_t < PRE_CYC + SOAK_CYC + m_tgt * D))) ? 1 : 0;
   endfunction

   always @(negedge clock) begin
      if (!reset) begin
         check("m_pump",  int'(pump),       exp_pump());
         check("m_stop",  int'(stop),       (m_phase == 2) ? 1 : 0);
         check("m_busy",  int'(busy),       (m_phase != 0) ? 1 : 0);
         check("m_fault", int'(fault),      (m_phase == 3) ? 1 : 0);
         check("m_pcnt",  int'(pour_count), m_pc);
      end
   end

   function automatic logic sig(input int w);
      case (w)
         S_PUMP:  return pump;
         S_STOP:  return stop;
         S_BUSY:  return busy;
         default: return fault;
      endcase
   endfunction

   task automatic step(input int k);
      repeat (k) @(negedge clock);
   endtask

   task automatic wait_for(input int w, input logic v, input string name);
      int n = 0;
      while (sig(w) !== v && n < 300) begin @(negedge clock); n++; end
      check(name, int'(sig(w)), int'(v));
   endtask

   task automatic wait_pc(input int pc, input string name);
      int n = 0;
      while (!(pump === 1'b1 && int'(pour_count) == pc) && n < 300) begin @(negedge clock); n++; end
      check(name, int'(pour_count), pc);
   endtask

   task automatic run_len(input int w, input logic v, output int n);
      n = 0;
      while (sig(w) === v && n < 300) begin n++; @(negedge clock); end
   endtask

   task automatic skip_pre(input string name);
`ifdef BREW_TIMER_PREINFUSE_EN
      int n;
      run_len(S_PUMP, 1'b1, n); check({name, "_pre_on"}, n, PON * D);
      run_len(S_PUMP, 1'b0, n); check({name, "_pre_soak"}, n, PSK * D);
`else
      check({name, "_no_pre"}, int'(pump), 1);
`endif
   endtask

   initial begin
      int n;
      step(2);
      check("rst_pump", int'(pump), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_pcnt", int'(pour_count), 0);
      reset = 1'b0;
      step(2);

      // small cup full cycle
      cup_size = 2'b00; brew = 1'b1;
      wait_for(S_PUMP, 1'b1, "t1_start");
      skip_pre("t1");
      run_len(S_PUMP, 1'b1, n); check("t1_pour_len", n, SM * D);
      run_len(S_STOP, 1'b0, n); check("t1_drip_len", n, DR * D);
      check("t1_stop", int'(stop), 1);
      check("t1_pcnt", int'(pour_count), SM);
      step(3);
      check("t1_stop_held", int'(stop), 1);
      brew = 1'b0; step(1);
      check("t1_stop_clr", int'(stop), 0);
      check("t1_idle", int'(busy), 0);

      // reserved cup code, cup_size changed mid-pour
      cup_size = 2'b11; brew = 1'b1;
      wait_for(S_PUMP, 1'b1, "t2_start");
      skip_pre("t2");
      step(2); cup_size = 2'b00;
      run_len(S_PUMP, 1'b1, n); check("t2_pour_len", n + 2, LG * D);
      check("t2_pcnt", int'(pour_count), LG);
      brew = 1'b0; step(2);

      // abort during medium pour
      cup_size = 2'b01; brew = 1'b1;
      wait_pc(2, "t3_reach2");
      abort = 1'b1; step(1);
      check("t3_pump", int'(pump), 0);
      check("t3_stop", int'(stop), 1);
      check("t3_pcnt", int'(pour_count), 2);
      abort = 1'b0; step(2);
      check("t3_pcnt_hold", int'(pour_count), 2);
      brew = 1'b0; step(1);
      check("t3_idle", int'(busy), 0);

      // water loss during pour
      cup_size = 2'b00; brew = 1'b1;
      wait_pc(1, "t4_reach1");
      water_ok = 1'b0; step(1);
      check("t4_pump", int'(pump), 0);
      check("t4_fault", int'(fault), 1);
      water_ok = 1'b1; brew = 1'b0; step(2); brew = 1'b1; step(2); brew = 1'b0; step(2);
      check("t4_fault_sticky", int'(fault), 1);
      reset = 1'b1; step(1); reset = 1'b0;
      check("t4_fault_clr", int'(fault), 0);
      step(2);

      // async reset mid-pour
      brew = 1'b1;
      wait_pc(1, "t5_reach1");
      @(posedge clock); #1 reset = 1'b1;
      #1;
      check("t5_async_pump", int'(pump), 0);
      check("t5_async_busy", int'(busy), 0);
      @(negedge clock); reset = 1'b0;
      step(20);
      check("t5_no_restart", int'(busy), 0);
      brew = 1'b0; step(1); brew = 1'b1;
      wait_for(S_BUSY, 1'b1, "t5_restart");
      brew = 1'b0; step(2);

      // randomized traffic
      repeat (4000) begin
         @(negedge clock);
         reset = ($urandom_range(0, 249) == 0);
         if ($urandom_range(0, 49) == 0) brew = ~brew;
         water_ok = ($urandom_range(0, 399) != 0);
         abort = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 9) == 0) cup_size = 2'($urandom_range(0, 3));
      end
      @(negedge clock); reset = 1'b0;
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
